hdb3_link_ctrl: RTL and testbench

//  Sequencing and supervision controller for the HDB3 receive decoder chain.
//  - Watches the rail pulses (p_in/n_in) at bit rate and checks HDB3 code rules.
//  - Acquires line lock, then enables the decoder datapath (dec_en) and flushes it once on lock.
//  - Declares loss-of-signal (LOS) and loss-of-lock, and keeps a saturating code-violation count.

---
 rtl/hdb3_link_ctrl_pkg.sv | 9 +
 rtl/hdb3_cv_detect.sv | 48 ++++
 rtl/hdb3_link_ctrl.sv | 73 +++++++
 tb/tb_hdb3_link_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/hdb3_link_ctrl_pkg.sv
// hdb3_link_ctrl_pkg: shared FSM states and default link supervision parameters
package hdb3_link_ctrl_pkg;
  typedef enum logic [1:0] {OFF = 2'd0, ACQ = 2'd1, LOCK = 2'd2, LOS = 2'd3} state_t;
  localparam int LOS_ZEROS = 32;
  localparam int ACQ_BITS = 16;
  localparam int WIN_BITS = 256;
  localparam int ERR_THR = 8;
  localparam int CNT_W = 16;
endpackage

// File: rtl/hdb3_cv_detect.sv
// hdb3_cv_detect: zero-run counter and pulse/V polarity trackers flagging HDB3 code violations
module hdb3_cv_detect
  import hdb3_link_ctrl_pkg::*;
#(
  parameter int LOS_Z = LOS_ZEROS
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic zclr,
  input  logic bit_en,
  input  logic p_in,
  input  logic n_in,
  output logic viol,
  output logic zero_los
);
  localparam int ZW = $clog2(LOS_Z + 1);
  logic [ZW-1:0] zcnt;
  logic last_p, seen, last_v, seen_v, pulse, is_v;
  always_comb begin
    pulse = p_in | n_in;
    is_v = seen & pulse & (p_in == last_p);
    viol = bit_en & ((p_in & n_in) | (~pulse & (zcnt == ZW'(3))) | (is_v & seen_v & (p_in == last_v)));
    zero_los = bit_en & ~pulse & (zcnt == ZW'(LOS_Z - 1));
  end
  always_ff @(posedge clk) begin
    if (rst || zclr) zcnt <= '0;
    else if (bit_en) zcnt <= pulse ? '0 : (zcnt == ZW'(LOS_Z)) ? zcnt : zcnt + ZW'(1);
  end
  // a pulse arriving together with clr seeds the tracker instead of being lost
  always_ff @(posedge clk) begin
    if (rst) begin
      {seen, last_p, seen_v, last_v} <= '0;
    end else if (clr) begin
      seen <= bit_en & pulse;
      last_p <= p_in;
      seen_v <= 1'b0;
      last_v <= 1'b0;
    end else if (bit_en && pulse) begin
      seen <= 1'b1;
      last_p <= p_in;
      if (is_v) begin
        seen_v <= 1'b1;
        last_v <= p_in;
      end
    end
  end
endmodule

// File: rtl/hdb3_link_ctrl.sv
// hdb3_link_ctrl: HDB3 receive lock acquisition, LOS/loss-of-lock supervision and violation counting
module hdb3_link_ctrl
  import hdb3_link_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             bit_en,
  input  logic             p_in,
  input  logic             n_in,
  input  logic             cnt_rd,
  output logic             dec_en,
  output logic             dec_flush,
  output logic             locked,
  output logic             los,
  output logic             cv_pulse,
  output logic [CNT_W-1:0] cv_cnt
);
  localparam int GW = $clog2(ACQ_BITS + 1);
  localparam int WW = $clog2(WIN_BITS);
  localparam int EW = $clog2(ERR_THR + 1);
  state_t state, state_n;
  logic viol, zero_los, act, cv, clr, zclr, good_done, err_hit, win_end;
  logic [GW-1:0] good;
  logic [WW-1:0] win;
  logic [EW-1:0] err, err_n;
  hdb3_cv_detect #(.LOS_Z(LOS_ZEROS)) u_det (
    .clk(clk), .rst(rst), .clr(clr), .zclr(zclr), .bit_en(bit_en),
    .p_in(p_in), .n_in(n_in), .viol(viol), .zero_los(zero_los)
  );
  always_comb begin
    act = enable && (state == ACQ || state == LOCK);
    cv = viol & act;
    err_n = err + EW'(viol);
    err_hit = err_n == EW'(ERR_THR);
    good_done = bit_en && !viol && good == GW'(ACQ_BITS - 1);
    win_end = bit_en && win == WW'(WIN_BITS - 1);
    state_n = state;
    if (!enable) state_n = OFF;
    else if (state == OFF) state_n = ACQ;
    else if (state == LOS) state_n = (bit_en && (p_in || n_in)) ? ACQ : LOS;
    else if (zero_los) state_n = LOS;
    else if (state == LOCK && err_hit) state_n = ACQ;
    else if (state == ACQ && good_done) state_n = LOCK;
    clr = state_n == ACQ && state != ACQ;
    zclr = !enable;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      good <= '0;
      win <= '0;
      err <= '0;
      dec_en <= 1'b0;
      dec_flush <= 1'b0;
      locked <= 1'b0;
      los <= 1'b0;
      cv_pulse <= 1'b0;
      cv_cnt <= '0;
    end else begin
      state <= state_n;
      good <= (state != ACQ || state_n != ACQ) ? '0 : bit_en ? (viol ? '0 : good + GW'(1)) : good;
      win <= (state != LOCK || state_n != LOCK || win_end) ? '0 : bit_en ? win + WW'(1) : win;
      err <= (state != LOCK || state_n != LOCK || win_end) ? '0 : err_n;
      dec_en <= state == LOCK && state_n == LOCK;
      dec_flush <= state == ACQ && state_n == LOCK;
      locked <= state_n == LOCK;
      los <= state_n == LOS;
      cv_pulse <= cv;
      cv_cnt <= cnt_rd ? CNT_W'(cv) : (cv && !(&cv_cnt)) ? cv_cnt + CNT_W'(1) : cv_cnt;
    end
  end
endmodule

// File: tb/tb_hdb3_link_ctrl.sv
// tb_hdb3_link_ctrl: directed self-checking bench for hdb3_link_ctrl
module tb_hdb3_link_ctrl;
  logic clk = 1'b0, rst, enable, bit_en, p_in, n_in, cnt_rd;
  logic dec_en, dec_flush, locked, los, cv_pulse;
  logic [15:0] cv_cnt;
  int n_chk = 0, n_err = 0;
  logic [1:0] t4_in [10] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
  logic t4_cv [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  int t4_cnt [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 3, 4};
  hdb3_link_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .bit_en(bit_en), .p_in(p_in), .n_in(n_in),
    .cnt_rd(cnt_rd), .dec_en(dec_en), .dec_flush(dec_flush), .locked(locked), .los(los),
    .cv_pulse(cv_pulse), .cv_cnt(cv_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic p, input logic n);
    @(negedge clk);
    bit_en = 1'b1;
    p_in = p;
    n_in = n;
    @(negedge clk);
    bit_en = 1'b0;
    p_in = 1'b0;
    n_in = 1'b0;
  endtask
  task automatic clean(input int k);
    send(k % 3 == 0, k % 3 == 1);
  endtask
  task automatic read_clr();
    @(negedge clk);
    cnt_rd = 1'b1;
    @(negedge clk);
    cnt_rd = 1'b0;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; enable = 1'b0; bit_en = 1'b0; p_in = 1'b0; n_in = 1'b0; cnt_rd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {dec_en, dec_flush, locked, los, cv_pulse}, 0);
    chk("rst_cnt", cv_cnt, 0);
    rst = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 15; k++) clean(k);
    chk("acq_15", locked, 0);
    clean(15);
    chk("lock_16", locked, 1);
    chk("flush_on", dec_flush, 1);
    chk("dec_en_entry", dec_en, 0);
    @(negedge clk);
    chk("flush_off", dec_flush, 0);
    chk("dec_en_lock", dec_en, 1);
    for (int i = 0; i < 31; i++) begin
      send(1'b0, 1'b0);
      if (i == 3) chk("zero4_pulse", cv_pulse, 1);
      if (i == 4) chk("zero5_quiet", cv_pulse, 0);
    end
    chk("pre_los", {los, locked}, 2'b01);
    send(1'b0, 1'b0);
    chk("los_on", {los, locked, dec_en}, 3'b100);
    chk("los_cv", cv_cnt, 1);
    send(1'b1, 1'b0);
    chk("los_exit", {los, locked}, 0);
    for (int k = 1; k < 16; k++) clean(k);
    chk("reacq_15", locked, 0);
    clean(16);
    chk("reacq_16", locked, 1);
    read_clr();
    chk("rd_clear", cv_cnt, 0);
    for (int g = 0; g < 8; g++) begin
      send(1'b1, 1'b1);
      if (g == 6) chk("thr_7_lock", {locked, cv_cnt}, {1'b1, 16'd7});
      if (g < 7) begin
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
      end
    end
    chk("thr_8_exit", {locked, dec_flush, dec_en}, 0);
    chk("thr_8_cnt", cv_cnt, 8);
    for (int k = 1; k <= 16; k++) clean(k);
    chk("relock_thr", locked, 1);
    read_clr();
    for (int k = 0; k < 232; k++) clean(k);
    for (int g = 0; g < 4; g++) begin
      send(1'b0, 1'b1); send(1'b1, 1'b0);
      repeat (4) send(1'b0, 1'b0);
    end
    chk("win1_lock", {locked, cv_cnt}, {1'b1, 16'd4});
    for (int g = 0; g < 4; g++) begin
      send(1'b0, 1'b1); send(1'b1, 1'b0);
      repeat (4) send(1'b0, 1'b0);
    end
    chk("win2_lock", {locked, cv_cnt}, {1'b1, 16'd8});
    read_clr();
    for (int i = 0; i < 10; i++) begin
      send(t4_in[i][1], t4_in[i][0]);
      chk($sformatf("v_pulse%0d", i), cv_pulse, t4_cv[i]);
      chk($sformatf("v_cnt%0d", i), cv_cnt, t4_cnt[i]);
    end
    chk("v_err_exit", locked, 0);
    @(negedge clk);
    bit_en = 1'b1; p_in = 1'b1; n_in = 1'b1;
    repeat (65536) @(negedge clk);
    chk("sat_ffff", cv_cnt, 16'hFFFF);
    cnt_rd = 1'b1;
    @(negedge clk);
    chk("rd_with_viol", cv_cnt, 1);
    bit_en = 1'b0; p_in = 1'b0; n_in = 1'b0;
    @(negedge clk);
    chk("rd_alone", cv_cnt, 0);
    cnt_rd = 1'b0;
    send(1'b1, 1'b1);
    for (int k = 1; k <= 16; k++) clean(k);
    chk("pre_off", {locked, cv_cnt}, {1'b1, 16'd1});
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("off_outs", {locked, dec_en, los, dec_flush}, 0);
    chk("off_cnt", cv_cnt, 1);
    send(1'b1, 1'b1);
    chk("off_no_cv", {cv_pulse, cv_cnt}, {1'b0, 16'd1});
    enable = 1'b1;
    @(negedge clk);
    clean(0);
    clean(1);
    @(negedge clk);
    rst = 1'b1; bit_en = 1'b1; p_in = 1'b1; n_in = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", {dec_en, dec_flush, locked, los, cv_pulse}, 0);
    chk("rst_mid_cnt", cv_cnt, 0);
    rst = 1'b0; bit_en = 1'b0; p_in = 1'b0; n_in = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
